// File: rtl/data_mem_ctrl_if.sv
// EX/MEM-to-data-memory request/response bundle.
// The pipeline drives the master side; the memory responder is the slave.
interface data_mem_ctrl_if;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] Addr_i;
  logic [31:0] Writedata_i;
  logic [31:0] Readdata_o;
  logic        Stall_o;
  logic        Valid_o;
  logic        Error_o;

  modport master (
    output MemRead_i, MemWrite_i, Addr_i, Writedata_i,
    input  Readdata_o, Stall_o, Valid_o, Error_o
  );

  modport slave (
    input  MemRead_i, MemWrite_i, Addr_i, Writedata_i,
    output Readdata_o, Stall_o, Valid_o, Error_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory responder for the MEM stage.
// Latches one aligned request, stalls the pipeline for LATENCY+1 cycles, then pulses Valid_o.
module data_mem_ctrl #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic           clk_i,
  input  logic           start_i,
  data_mem_ctrl_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_write;
  logic [AW-1:0]      r_idx;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_error;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic w_req;
  logic w_aligned;
  logic w_valid_req;
  logic w_misaligned;
  logic w_do_access;
  logic w_unused_addr;

  assign w_req         = bus.MemRead_i | bus.MemWrite_i;
  assign w_aligned     = (bus.Addr_i[1:0] == 2'b00);
  assign w_valid_req   = w_req & w_aligned;
  assign w_misaligned  = w_req & ~w_aligned;
  assign w_do_access   = (r_state == BUSY) && (r_cnt == '0);
  // Upper address bits alias by design.
  assign w_unused_addr = ^{bus.Addr_i[31:AW+2]};

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) r_state <= IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (w_valid_req) w_next_state = BUSY;
      BUSY:    if (r_cnt == '0) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Stall is gated by reset so an idle-state request cannot assert it during reset.
  always_comb begin
    bus.Stall_o    = start_i & (((r_state == IDLE) & w_valid_req) | (r_state == BUSY));
    bus.Valid_o    = (r_state == DONE);
    bus.Readdata_o = r_rdata;
    bus.Error_o    = r_error;
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        if (w_misaligned) r_error <= 1'b1;
        if (w_valid_req) begin
          r_is_write <= bus.MemWrite_i;
          r_idx      <= bus.Addr_i[AW+1:2];
          r_wdata    <= bus.Writedata_i;
          r_cnt      <= CNT_W'(LATENCY - 1);
        end
      end else if ((r_state == BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_do_access && !r_is_write) r_rdata <= r_mem[r_idx];
    end
  end

  // Storage is intentionally not reset; a reset holds the FSM in IDLE, which blocks writes.
  always_ff @(posedge clk_i) begin
    if (w_do_access && r_is_write) r_mem[r_idx] <= r_wdata;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: LATENCY=2 instance for the main flows,
// LATENCY=1 instance for back-to-back held requests.
module tb_data_mem_ctrl;

  logic clk_i;
  logic start_i;
  int   checks;
  int   failures;

  data_mem_ctrl_if a_if ();
  data_mem_ctrl_if b_if ();

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut_a (
    .clk_i   (clk_i),
    .start_i (start_i),
    .bus     (a_if.slave)
  );

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_b (
    .clk_i   (clk_i),
    .start_i (start_i),
    .bus     (b_if.slave)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd);
    a_if.MemRead_i   = rd;
    a_if.MemWrite_i  = wr;
    a_if.Addr_i      = addr;
    a_if.Writedata_i = wd;
  endtask

  // Presents a request on instance A, holds it until DONE, then drops it; observes 8 cycles.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, output int stalls, output int valids,
                           output logic [31:0] rdata);
    bit done;
    stalls = 0;
    valids = 0;
    rdata  = 'x;
    done   = 1'b0;
    @(posedge clk_i); #1;
    drive_a(rd, wr, addr, wd);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      if (a_if.Stall_o) stalls++;
      if (a_if.Valid_o) begin
        valids++;
        rdata = a_if.Readdata_o;
        done  = 1'b1;
      end
      @(posedge clk_i); #1;
      if (done) drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    end
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  int          st;
  int          vl;
  logic [31:0] rd;
  logic [7:0]  stall_vec;
  logic [7:0]  valid_vec;

  initial begin
    checks   = 0;
    failures = 0;
    start_i  = 1'b0;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    b_if.MemRead_i   = 1'b0;
    b_if.MemWrite_i  = 1'b0;
    b_if.Addr_i      = 32'h0;
    b_if.Writedata_i = 32'h0;

    // Reset state, including a request presented while in reset
    #2;
    drive_a(1'b1, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_stall_with_req", 32'(a_if.Stall_o), 32'd0);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("rst_rdata", a_if.Readdata_o, 32'h0);
    chk("rst_valid", 32'(a_if.Valid_o), 32'd0);
    chk("rst_error", 32'(a_if.Error_o), 32'd0);
    repeat (2) @(negedge clk_i);
    start_i = 1'b1;

    // Store then load
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, st, vl, rd);
    chk("st10_stalls", 32'(st), 32'd3);
    chk("st10_valids", 32'(vl), 32'd1);
    chk("st10_rdata_unchanged", rd, 32'h0);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, st, vl, rd);
    chk("ld10_stalls", 32'(st), 32'd3);
    chk("ld10_valids", 32'(vl), 32'd1);
    chk("ld10_rdata", rd, 32'hDEADBEEF);

    // Misaligned load
    @(posedge clk_i); #1;
    drive_a(1'b1, 1'b0, 32'h13, 32'h0);
    @(negedge clk_i);
    chk("mis_stall", 32'(a_if.Stall_o), 32'd0);
    chk("mis_valid", 32'(a_if.Valid_o), 32'd0);
    chk("mis_err_before_edge", 32'(a_if.Error_o), 32'd0);
    @(posedge clk_i); #1;
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    chk("mis_err_set", 32'(a_if.Error_o), 32'd1);
    chk("mis_valid_after", 32'(a_if.Valid_o), 32'd0);
    chk("mis_rdata_held", a_if.Readdata_o, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h10, 32'h0, st, vl, rd);
    chk("post_mis_ld_valids", 32'(vl), 32'd1);
    chk("post_mis_ld_rdata", rd, 32'hDEADBEEF);
    chk("err_sticky", 32'(a_if.Error_o), 32'd1);

    // Address aliasing modulo 1 KiB
    do_access(1'b0, 1'b1, 32'h400, 32'h12345678, st, vl, rd);
    do_access(1'b1, 1'b0, 32'h0, 32'h0, st, vl, rd);
    chk("alias_rdata", rd, 32'h12345678);

    // Reset during BUSY aborts the store
    do_access(1'b0, 1'b1, 32'h20, 32'h11111111, st, vl, rd);
    @(posedge clk_i); #1;
    drive_a(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5);
    @(negedge clk_i);
    chk("abort_stall_idle", 32'(a_if.Stall_o), 32'd1);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    #1;
    chk("abort_rst_stall", 32'(a_if.Stall_o), 32'd0);
    chk("abort_rst_valid", 32'(a_if.Valid_o), 32'd0);
    chk("abort_rst_error", 32'(a_if.Error_o), 32'd0);
    chk("abort_rst_rdata", a_if.Readdata_o, 32'h0);
    drive_a(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk_i);
    start_i = 1'b1;
    do_access(1'b1, 1'b0, 32'h20, 32'h0, st, vl, rd);
    chk("abort_ld_rdata", rd, 32'h11111111);

    // Read and write together: store wins, read ignored
    do_access(1'b1, 1'b1, 32'h8, 32'h55, st, vl, rd);
    chk("rw_valids", 32'(vl), 32'd1);
    chk("rw_rdata_unchanged", rd, 32'h11111111);
    chk("rw_no_error", 32'(a_if.Error_o), 32'd0);
    do_access(1'b1, 1'b0, 32'h8, 32'h0, st, vl, rd);
    chk("rw_ld_rdata", rd, 32'h55);

    // LATENCY=1: store, then a load held for 8 cycles
    @(posedge clk_i); #1;
    b_if.MemWrite_i  = 1'b1;
    b_if.Addr_i      = 32'h4;
    b_if.Writedata_i = 32'hCAFEF00D;
    repeat (3) @(posedge clk_i);
    #1;
    b_if.MemWrite_i  = 1'b0;
    b_if.Writedata_i = 32'h0;
    @(posedge clk_i); #1;
    b_if.MemRead_i = 1'b1;
    stall_vec = '0;
    valid_vec = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      stall_vec = {stall_vec[6:0], b_if.Stall_o};
      valid_vec = {valid_vec[6:0], b_if.Valid_o};
    end
    chk("b2b_stall_pattern", 32'(stall_vec), 32'h000000DB);
    chk("b2b_valid_pattern", 32'(valid_vec), 32'h00000024);
    chk("b2b_rdata", b_if.Readdata_o, 32'hCAFEF00D);
    b_if.MemRead_i = 1'b0;
    repeat (2) @(negedge clk_i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
